// File: rtl/regfile_pkg.sv
// Shared constants and index legality helper for the register file and its scoreboard.
package regfile_pkg;

  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;

  // An index is usable when it names an existing register that is not the hard-wired zero.
  function automatic logic idx_legal(input int idx, input int nregs, input bit zero_reg);
    return (idx < nregs) && !(zero_reg && idx == 0);
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on issue, cleared on writeback, with an incrementally kept popcount.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS    = NREGS_DEF,
  parameter  int ZERO_REG = 1,
  localparam int IDXW     = $clog2(NREGS),
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en_i,
  input  logic [IDXW-1:0]  set_idx_i,
  input  logic             clr_en_i,
  input  logic [IDXW-1:0]  clr_idx_i,
  output logic [NREGS-1:0] busy_o,
  output logic [CW-1:0]    busy_cnt_o
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             set_ok, clr_ok, inc, dec;

  always_comb begin
    set_ok = set_en_i && idx_legal(int'(set_idx_i), NREGS, ZERO_REG != 0);
    clr_ok = clr_en_i && idx_legal(int'(clr_idx_i), NREGS, ZERO_REG != 0);
    busy_d = busy_q;
    if (clr_ok) busy_d[clr_idx_i] = 1'b0;
    // Set is applied last: a newly issued producer outranks the retiring one.
    if (set_ok) busy_d[set_idx_i] = 1'b1;
    inc = set_ok && !busy_q[set_idx_i];
    dec = clr_ok && busy_q[clr_idx_i] && !(set_ok && set_idx_i == clr_idx_i);
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + CW'(1);
    else if (dec && !inc) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with optional zero register, writeback bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int XLEN     = XLEN_DEF,
  parameter  int NREGS    = NREGS_DEF,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int IDXW     = $clog2(NREGS),
  localparam int CW       = $clog2(NREGS + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDXW-1:0]     wr_idx,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [IDXW-1:0]     rsv_idx,
  input  logic [NRD*IDXW-1:0] rd_idx,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  output logic [CW-1:0]       busy_cnt
);

  logic [NREGS-1:0][XLEN-1:0] regs_q;
  logic [NREGS-1:0]           busy;
  logic                       wr_ok;

  assign wr_ok = wr_en && idx_legal(int'(wr_idx), NREGS, ZERO_REG != 0);

  always_ff @(posedge clk) begin
    if (reset)      regs_q         <= '0;
    else if (wr_ok) regs_q[wr_idx] <= wr_data;
  end

  rf_scoreboard #(.NREGS(NREGS), .ZERO_REG(ZERO_REG)) u_sb (
    .clk        (clk),
    .reset      (reset),
    .set_en_i   (rsv_en),
    .set_idx_i  (rsv_idx),
    .clr_en_i   (wr_en),
    .clr_idx_i  (wr_idx),
    .busy_o     (busy),
    .busy_cnt_o (busy_cnt)
  );

  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [IDXW-1:0] idx;
    logic [XLEN-1:0] data_p;
    logic            busy_p, legal, hit, rsv_same;

    assign idx = rd_idx[p*IDXW +: IDXW];

    always_comb begin
      legal    = idx_legal(int'(idx), NREGS, ZERO_REG != 0);
      hit      = (BYPASS != 0) && wr_ok && (wr_idx == idx);
      rsv_same = rsv_en && (rsv_idx == idx);
      data_p   = '0;
      busy_p   = 1'b0;
      if (legal) begin
        data_p = regs_q[idx];
        busy_p = busy[idx];
      end
      // A forwarded writeback frees the register unless a new producer issues
      // to it this cycle; that reservation only shows up after the edge.
      if (hit) begin
        data_p = wr_data;
        if (!rsv_same) busy_p = 1'b0;
      end
    end

    assign rd_data[p*XLEN +: XLEN] = data_p;
    assign rd_busy[p]              = busy_p;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Three configurations (default, no bypass, 24 registers) driven in lockstep against a behavioural model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en, rsv_en;
  logic [4:0]  wr_idx, rsv_idx;
  logic [63:0] wr_data;
  logic [9:0]  rd_idx;

  logic [127:0] rd_data0, rd_data1, rd_data2;
  logic [1:0]   rd_busy0, rd_busy1, rd_busy2;
  logic [5:0]   busy_cnt0, busy_cnt1;
  logic [4:0]   busy_cnt2;

  always #5 clk = ~clk;

  regfile_sb u0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .rd_idx(rd_idx),
    .rd_data(rd_data0), .rd_busy(rd_busy0), .busy_cnt(busy_cnt0)
  );
  regfile_sb #(.BYPASS(0)) u1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .rd_idx(rd_idx),
    .rd_data(rd_data1), .rd_busy(rd_busy1), .busy_cnt(busy_cnt1)
  );
  regfile_sb #(.NREGS(24)) u2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_idx(rsv_idx), .rd_idx(rd_idx),
    .rd_data(rd_data2), .rd_busy(rd_busy2), .busy_cnt(busy_cnt2)
  );

  // Model: architectural contents and busy flags per configuration.
  int          nregs_c [3] = '{32, 32, 24};
  bit          byp_c   [3] = '{1'b1, 1'b0, 1'b1};
  logic [63:0] mreg    [3][32];
  bit          mbusy   [3][32];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  function automatic bit legal(input int c, input int idx);
    return idx < nregs_c[c] && idx != 0;
  endfunction

  task automatic model_edge();
    for (int c = 0; c < 3; c++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) begin
          mreg[c][r]  = '0;
          mbusy[c][r] = 1'b0;
        end
      end else begin
        if (wr_en && legal(c, int'(wr_idx))) begin
          mreg[c][wr_idx]  = wr_data;
          mbusy[c][wr_idx] = 1'b0;
        end
        if (rsv_en && legal(c, int'(rsv_idx))) mbusy[c][rsv_idx] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 3; c++) begin
      int nb = 0;
      logic [63:0] cnt_obs;
      for (int r = 0; r < 32; r++) nb += int'(mbusy[c][r]);
      for (int p = 0; p < 2; p++) begin
        int          idx = int'(rd_idx[p*5 +: 5]);
        logic [63:0] ed, od;
        logic        eb, ob;
        ed = '0;
        eb = 1'b0;
        if (legal(c, idx)) begin
          ed = mreg[c][idx];
          eb = mbusy[c][idx];
          if (byp_c[c] && wr_en && int'(wr_idx) == idx) begin
            ed = wr_data;
            if (!(rsv_en && int'(rsv_idx) == idx)) eb = 1'b0;
          end
        end
        case (c)
          0:       begin od = rd_data0[p*64 +: 64]; ob = rd_busy0[p]; end
          1:       begin od = rd_data1[p*64 +: 64]; ob = rd_busy1[p]; end
          default: begin od = rd_data2[p*64 +: 64]; ob = rd_busy2[p]; end
        endcase
        chk($sformatf("cfg%0d rd_data[%0d] idx%0d", c, p, idx), od, ed);
        chk($sformatf("cfg%0d rd_busy[%0d] idx%0d", c, p, idx), 64'(ob), 64'(eb));
      end
      case (c)
        0:       cnt_obs = 64'(busy_cnt0);
        1:       cnt_obs = 64'(busy_cnt1);
        default: cnt_obs = 64'(busy_cnt2);
      endcase
      chk($sformatf("cfg%0d busy_cnt", c), cnt_obs, 64'(nb));
    end
  endtask

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; rsv_en = 1'b0;
    wr_idx = '0; rsv_idx = '0; wr_data = '0; rd_idx = {5'd2, 5'd1};
    @(posedge clk);
    model_edge();
    #1;
    cycle();

    // Reset state
    idle(); rd_idx = {5'd2, 5'd1};
    #1;
    chk("reset rd_data p0", rd_data0[63:0], 64'd0);
    chk("reset rd_data p1", rd_data0[127:64], 64'd0);
    chk("reset rd_busy", 64'(rd_busy0), 64'd0);
    chk("reset busy_cnt", 64'(busy_cnt0), 64'd0);
    cycle();

    // Write then bypassed write
    wr_en = 1'b1; wr_idx = 5'd1; wr_data = 64'd5;
    cycle();
    wr_idx = 5'd2; wr_data = 64'd10;
    #1;
    chk("bypass r1", rd_data0[63:0], 64'd5);
    chk("bypass r2", rd_data0[127:64], 64'd10);
    chk("nobypass r2", rd_data1[127:64], 64'd0);
    cycle();
    idle();
    #1;
    chk("nobypass r2 after edge", rd_data1[127:64], 64'd10);
    cycle();

    // Zero register
    wr_en = 1'b1; wr_idx = 5'd0; wr_data = '1; rd_idx = {5'd0, 5'd0};
    cycle();
    idle(); rsv_en = 1'b1; rsv_idx = 5'd0;
    cycle();
    idle();
    #1;
    chk("r0 data", rd_data0[63:0], 64'd0);
    chk("r0 rsv busy_cnt", 64'(busy_cnt0), 64'd0);
    cycle();

    // Reserve r3, r4; writeback r3
    rsv_en = 1'b1; rsv_idx = 5'd3; rd_idx = {5'd4, 5'd3};
    cycle();
    rsv_idx = 5'd4;
    cycle();
    idle();
    #1;
    chk("rsv busy_cnt 2", 64'(busy_cnt0), 64'd2);
    chk("rsv rd_busy r3", 64'(rd_busy0[0]), 64'd1);
    cycle();
    wr_en = 1'b1; wr_idx = 5'd3; wr_data = 64'd7;
    #1;
    chk("wb r3 busy", 64'(rd_busy0[0]), 64'd0);
    chk("wb r3 data", rd_data0[63:0], 64'd7);
    cycle();
    idle();
    #1;
    chk("wb busy_cnt 1", 64'(busy_cnt0), 64'd1);
    cycle();

    // Simultaneous write and reserve on r5
    wr_en = 1'b1; rsv_en = 1'b1; wr_idx = 5'd5; rsv_idx = 5'd5; wr_data = 64'd9;
    rd_idx = {5'd5, 5'd5};
    cycle();
    idle();
    #1;
    chk("set wins data", rd_data0[63:0], 64'd9);
    chk("set wins busy", 64'(rd_busy0[0]), 64'd1);
    chk("set wins cnt", 64'(busy_cnt0), 64'd2);
    cycle();

    // Out of range on 24-entry config, then reset with pending write
    wr_en = 1'b1; rsv_en = 1'b1; wr_idx = 5'd30; rsv_idx = 5'd30; wr_data = 64'hABCD;
    rd_idx = {5'd30, 5'd30};
    cycle();
    idle(); rsv_en = 1'b1; rsv_idx = 5'd6;
    #1;
    chk("oor data", rd_data2[63:0], 64'd0);
    chk("oor busy", 64'(rd_busy2[0]), 64'd0);
    chk("oor cnt", 64'(busy_cnt2), 64'd2);
    cycle();
    idle(); reset = 1'b1; wr_en = 1'b1; wr_idx = 5'd6; wr_data = 64'd3; rd_idx = {5'd6, 5'd6};
    cycle();
    idle();
    #1;
    chk("reset r6 data", rd_data0[63:0], 64'd0);
    chk("reset busy_cnt", 64'(busy_cnt0), 64'd0);
    cycle();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 59) == 0);
      wr_en   = 1'($urandom_range(0, 1));
      rsv_en  = ($urandom_range(0, 2) != 0);
      wr_idx  = 5'($urandom_range(0, 31));
      rsv_idx = ($urandom_range(0, 5) == 0) ? wr_idx : 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      rd_idx[4:0] = ($urandom_range(0, 3) == 0) ? wr_idx : 5'($urandom_range(0, 31));
      rd_idx[9:5] = ($urandom_range(0, 3) == 0) ? rd_idx[4:0] : 5'($urandom_range(0, 31));
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
